sim_run_controller: RTL and testbench
=====================================

// Module: sim_run_controller
// PURPOSE
//  Parametrised run/verdict controller for the RISC-V processor top in simulation and FPGA bring-up.
//  - Watches retired PC and data-memory write port; decides run end: PASS, FAIL, HALT (PC stuck) or TIMEOUT.
//  - Replaces fixed-delay $stop and narrow PC probing with a sticky, cycle-exact verdict and counters.
// PARAMETERS
//  XLEN        32            data/address width of memory write port
//  PC_W        32            width of observed PC (generalises 4-bit debug PC probe)
//  MAX_CYCLES  1000          run cycles before TIMEOUT
//  STALL_LIMIT 8             consecutive identical PC samples that declare HALT (>=2)
//  TOHOST_ADDR 32'h0000_0064 verdict write address
//  PASS_DATA   32'd25        data at TOHOST_ADDR meaning PASS; any other value = FAIL
// PORTS
//  clk          in  1     core clock
//  reset        in  1     asynchronous, active-high reset
//  pc           in  PC_W  current fetch PC from core
//  memwrite     in  1     data-memory write strobe (M stage)
//  dataadr      in  XLEN  data-memory write address
//  writedata    in  XLEN  data-memory write data
//  done         out 1     run finished (any terminal state)
//  pass         out 1     PASS verdict
//  fail         out 1     FAIL verdict
//  halted       out 1     PC stuck for STALL_LIMIT samples
//  timeout      out 1     MAX_CYCLES reached
//  cycle_count  out 32    run cycles, frozen at terminal state
//  halt_pc      out PC_W  PC at HALT, else 0
//  fail_data    out XLEN  data of failing tohost write, else 0
//  signature    out XLEN  write-data signature (see CONFIGURATION)
// BEHAVIOUR
//  - reset=1: immediately (no clock) state=RUN, all outputs 0, internal last_pc=0, stall_cnt=0.
//  - States: RUN, PASS, FAIL, HALT, TIMEOUT. Terminal states are sticky until reset; done=1 in all four.
//  - RUN, per rising edge: cycle_count+=1; last_pc<=pc; stall_cnt<= (pc==last_pc) ? stall_cnt+1 : 0.
//  - Verdict registered on the edge where condition is sampled; flags visible one cycle after sampled inputs.
//  - memwrite && dataadr==TOHOST_ADDR: writedata==PASS_DATA -> PASS; else -> FAIL, fail_data<=writedata.
//  - Writes to other addresses never change state.
//  - pc==last_pc && stall_cnt==STALL_LIMIT-1 -> HALT, halt_pc<=pc.
//  - cycle_count==MAX_CYCLES-1 -> TIMEOUT (count reaches MAX_CYCLES and freezes).
//  - Simultaneous conditions, priority: tohost write > HALT > TIMEOUT.
//  - cycle_count increments on the transition edge, then freezes; counters never wrap.
//  - First edge after reset compares against last_pc=0: pc==0 counts as one stall sample.
//  - reset mid-run: asynchronous return to RUN with all state cleared; no partial verdict retained.
// CONFIGURATION
//  RUN_CTRL_SIG_EN defined: in RUN, each memwrite (any address) does signature<=rotl(signature,1)^writedata.
//  Signature freezes in terminal states; reset clears to 0.
//  RUN_CTRL_SIG_EN undefined: no signature register; port tied to 0.
// STRUCTURE
//  Package run_ctrl_pkg: run_state_t enum {RUN,PASS,FAIL,HALT,TIMEOUT}, CYC_W=32 constant.
//  Package also holds rotl helper function.
//  Sub-module sat_counter (WIDTH, MAX; async-reset, inc/clr/freeze): used for cycle and stall counters.
// TESTING
//  1 reset 15ns; pc+=4/cycle; write addr 0x64 data 25 on cycle 20 -> next cycle done=1 pass=1, cycle_count=20 held.
//  2 write addr 0x64 data 7 -> fail=1 fail_data=7 pass=0; later write 0x64/25 ignored.
//  3 pc held 0x44 for 8 samples -> halted=1 halt_pc=0x44 after 8th; 7 samples then change -> no HALT.
//  4 MAX_CYCLES=50, pc incrementing, no tohost write -> timeout=1, cycle_count=50, stays.
//  5 tohost 0x64/25 on same edge as HALT and TIMEOUT -> pass=1 only; halted=0 timeout=0.
//  6 reset pulse mid-run, off-edge -> all outputs 0 before next clk; new run restarts at count 0.
//  7 (RUN_CTRL_SIG_EN) writes data 1 then 3 to addr 0x10 -> signature=1; without macro signature=0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - verdict states, counter width and rotate helper for sim_run_controller
package run_ctrl_pkg;

  typedef enum logic [2:0] {RUN, PASS, FAIL, HALT, TIMEOUT} run_state_t;

  localparam int CYC_W = 32;

  // Rotate the low 'width' bits of v left by amt (amt < width <= 64); upper bits return 0.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned amt,
                                       input int unsigned width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return ((v << amt) | ((v & mask) >> (width - amt))) & mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear and freeze, async active-high reset
module sat_counter #(
  parameter int WIDTH = 32,
  parameter int MAX   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             freeze,
  output logic [WIDTH-1:0] count
);

  // freeze wins over clr so terminal-state counts stay exactly as they were
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!freeze) begin
      if (clr) begin
        count <= '0;
      end else if (inc && count != WIDTH'(MAX)) begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/sim_run_controller.sv
// rtl/sim_run_controller.sv - sticky PASS/FAIL/HALT/TIMEOUT run verdict for the RISC-V sim top
// Optional write-data signature enabled by defining RUN_CTRL_SIG_EN.
module sim_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              PC_W        = 32,
  parameter int              MAX_CYCLES  = 1000,
  parameter int              STALL_LIMIT = 8,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0064,
  parameter logic [XLEN-1:0] PASS_DATA   = 32'd25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             memwrite,
  input  logic [XLEN-1:0]  dataadr,
  input  logic [XLEN-1:0]  writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             halted,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count,
  output logic [PC_W-1:0]  halt_pc,
  output logic [XLEN-1:0]  fail_data,
  output logic [XLEN-1:0]  signature
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  run_state_t         state;
  logic [PC_W-1:0]    last_pc;
  logic [STALL_W-1:0] stall_cnt;
  logic               running;
  logic               pc_same;
  logic               tohost_hit;
  logic               halt_hit;
  logic               time_hit;

  assign running    = (state == RUN);
  assign pc_same    = (pc == last_pc);
  assign tohost_hit = memwrite && (dataadr == TOHOST_ADDR);
  assign halt_hit   = pc_same && (stall_cnt == STALL_W'(STALL_LIMIT - 1));
  assign time_hit   = (cycle_count == CYC_W'(MAX_CYCLES - 1));

  // Both counters step on the transition edge itself, then freeze outside RUN.
  sat_counter #(.WIDTH(CYC_W), .MAX(MAX_CYCLES)) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (running),
    .clr    (1'b0),
    .freeze (!running),
    .count  (cycle_count)
  );

  sat_counter #(.WIDTH(STALL_W), .MAX(STALL_LIMIT)) u_stall_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (pc_same),
    .clr    (!pc_same),
    .freeze (!running),
    .count  (stall_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      last_pc   <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      halted    <= 1'b0;
      timeout   <= 1'b0;
      halt_pc   <= '0;
      fail_data <= '0;
    end else if (running) begin
      last_pc <= pc;
      // Priority: tohost write, then PC stall, then cycle budget.
      if (tohost_hit) begin
        done <= 1'b1;
        if (writedata == PASS_DATA) begin
          state <= PASS;
          pass  <= 1'b1;
        end else begin
          state     <= FAIL;
          fail      <= 1'b1;
          fail_data <= writedata;
        end
      end else if (halt_hit) begin
        state   <= HALT;
        done    <= 1'b1;
        halted  <= 1'b1;
        halt_pc <= pc;
      end else if (time_hit) begin
        state   <= TIMEOUT;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

`ifdef RUN_CTRL_SIG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      signature <= '0;
    end else if (running && memwrite) begin
      signature <= XLEN'(rotl(64'(signature), 1, XLEN)) ^ writedata;
    end
  end
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// tb/tb_sim_run_controller.sv - randomized self-checking bench for sim_run_controller
module tb_sim_run_controller;

  localparam int          XLEN        = 32;
  localparam int          PC_W        = 32;
  localparam int          MAX_CYCLES  = 50;
  localparam int          STALL_LIMIT = 8;
  localparam logic [31:0] TOHOST      = 32'h64;
  localparam logic [31:0] PASS_VAL    = 32'd25;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        done, pass, fail, halted, timeout;
  logic [31:0] cycle_count, halt_pc, fail_data, signature;

  int total = 0;
  int bad = 0;

  // Reference model: 0 run, 1 pass, 2 fail, 3 halt, 4 timeout
  int          m_state;
  int          m_cycles;
  int          m_matches;
  logic [31:0] m_prev_pc, m_halt_pc, m_fail_data, m_sig;

  sim_run_controller #(
    .XLEN(XLEN), .PC_W(PC_W), .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT),
    .TOHOST_ADDR(TOHOST), .PASS_DATA(PASS_VAL)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail(fail), .halted(halted),
    .timeout(timeout), .cycle_count(cycle_count), .halt_pc(halt_pc),
    .fail_data(fail_data), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cycles = 0; m_matches = 0;
    m_prev_pc = '0; m_halt_pc = '0; m_fail_data = '0; m_sig = '0;
  endtask

  // Applies the rules to the inputs sampled on one rising edge.
  task automatic model_edge();
    if (m_state == 0) begin
      m_cycles++;
      m_matches = (pc == m_prev_pc) ? m_matches + 1 : 0;
      m_prev_pc = pc;
`ifdef RUN_CTRL_SIG_EN
      if (memwrite) m_sig = {m_sig[30:0], m_sig[31]} ^ writedata;
`endif
      if (memwrite && dataadr == TOHOST) begin
        if (writedata == PASS_VAL) m_state = 1;
        else begin
          m_state = 2;
          m_fail_data = writedata;
        end
      end else if (m_matches >= STALL_LIMIT) begin
        m_state = 3;
        m_halt_pc = pc;
      end else if (m_cycles >= MAX_CYCLES) begin
        m_state = 4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".done"},    64'(done),        64'(m_state != 0));
    check({tag, ".pass"},    64'(pass),        64'(m_state == 1));
    check({tag, ".fail"},    64'(fail),        64'(m_state == 2));
    check({tag, ".halted"},  64'(halted),      64'(m_state == 3));
    check({tag, ".timeout"}, 64'(timeout),     64'(m_state == 4));
    check({tag, ".cycles"},  64'(cycle_count), 64'(m_cycles));
    check({tag, ".halt_pc"}, 64'(halt_pc),     64'(m_halt_pc));
    check({tag, ".fdata"},   64'(fail_data),   64'(m_fail_data));
    check({tag, ".sig"},     64'(signature),   64'(m_sig));
  endtask

  // Called at a falling edge: drive, take one rising edge, compare on the next falling edge.
  task automatic cyc(input string tag, input logic [31:0] p, input logic mw,
                     input logic [31:0] a, input logic [31:0] d);
    pc = p; memwrite = mw; dataadr = a; writedata = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic start_run(input string tag);
    reset = 1'b1; pc = '0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    #1;
    model_reset();
    check_all({tag, ".rst"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] exp_sig;
  logic [31:0] rp, ra, rd;
  logic        rmw;

  initial begin
    model_reset();
    #1 check_all("por");
    #14 reset = 1'b0;

    // 1: PASS on the 20th edge, count held afterwards
    for (int k = 0; k < 19; k++) cyc("t1", 32'(4 * k), 1'b0, '0, '0);
    cyc("t1w", 32'd76, 1'b1, TOHOST, 32'd25);
    for (int k = 0; k < 3; k++) cyc("t1h", 32'(80 + 4 * k), 1'b0, '0, '0);
    check("t1.pass_const", 64'(pass), 64'd1);
    check("t1.count_const", 64'(cycle_count), 64'd20);

    // 2: FAIL with data 7; a later PASS write is ignored
    start_run("t2");
    for (int k = 0; k < 5; k++) cyc("t2", 32'(4 * k), 1'b0, '0, '0);
    cyc("t2w", 32'd20, 1'b1, TOHOST, 32'd7);
    cyc("t2x", 32'd24, 1'b1, TOHOST, 32'd25);
    check("t2.fail_const", 64'(fail), 64'd1);
    check("t2.fdata_const", 64'(fail_data), 64'd7);
    check("t2.pass_const", 64'(pass), 64'd0);

    // 3a: PC stuck at 0x44 long enough for STALL_LIMIT identical samples
    start_run("t3a");
    for (int k = 0; k < 4; k++) cyc("t3a", 32'(32'h30 + 4 * k), 1'b0, '0, '0);
    for (int k = 0; k <= STALL_LIMIT; k++) cyc("t3a_s", 32'h44, 1'b0, '0, '0);
    check("t3a.halted_const", 64'(halted), 64'd1);
    check("t3a.halt_pc_const", 64'(halt_pc), 64'h44);

    // 3b: one identical sample short, then PC moves on
    start_run("t3b");
    cyc("t3b", 32'h40, 1'b0, '0, '0);
    for (int k = 0; k < STALL_LIMIT; k++) cyc("t3b_s", 32'h44, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) cyc("t3b_m", 32'(32'h48 + 4 * k), 1'b0, '0, '0);
    check("t3b.halted_const", 64'(halted), 64'd0);

    // 4: TIMEOUT at MAX_CYCLES, count frozen
    start_run("t4");
    for (int k = 0; k < MAX_CYCLES + 5; k++) cyc("t4", 32'(4 + 4 * k), 1'b0, '0, '0);
    check("t4.timeout_const", 64'(timeout), 64'd1);
    check("t4.count_const", 64'(cycle_count), 64'(MAX_CYCLES));

    // 5: tohost PASS on the edge that would also be HALT and TIMEOUT
    start_run("t5");
    for (int k = 1; k <= MAX_CYCLES - 9; k++) cyc("t5", 32'(4 * k), 1'b0, '0, '0);
    for (int k = 0; k < 8; k++) cyc("t5_s", 32'h200, 1'b0, '0, '0);
    cyc("t5w", 32'h200, 1'b1, TOHOST, PASS_VAL);
    check("t5.pass_const", 64'(pass), 64'd1);
    check("t5.halted_const", 64'(halted), 64'd0);
    check("t5.timeout_const", 64'(timeout), 64'd0);
    check("t5.count_const", 64'(cycle_count), 64'(MAX_CYCLES));

    // 6: asynchronous reset mid-run between clock edges
    start_run("t6");
    for (int k = 0; k < 10; k++) cyc("t6", 32'(4 * k), 1'b0, '0, '0);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("t6.async");
    check("t6.count_zero", 64'(cycle_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cyc("t6r", 32'(4 + 4 * k), 1'b0, '0, '0);
    check("t6.count_restart", 64'(cycle_count), 64'd3);

    // 7: signature over two ordinary writes
    start_run("t7");
    cyc("t7a", 32'd4, 1'b1, 32'h10, 32'd1);
    cyc("t7b", 32'd8, 1'b1, 32'h10, 32'd3);
`ifdef RUN_CTRL_SIG_EN
    exp_sig = 32'd1;
`else
    exp_sig = 32'd0;
`endif
    check("t7.sig_const", 64'(signature), 64'(exp_sig));

    // Randomized runs: sticky PC, sparse tohost writes, mixed data
    for (int r = 0; r < 20; r++) begin
      start_run("rnd");
      rp = 32'($urandom_range(0, 3) * 4);
      for (int k = 0; k < MAX_CYCLES + 10; k++) begin
        if ($urandom_range(0, 99) < 15) rp = 32'($urandom_range(0, 7) * 4);
        rmw = ($urandom_range(0, 99) < 30);
        case ($urandom_range(0, 2))
          0: ra = ($urandom_range(0, 99) < 15) ? TOHOST : 32'h10;
          1: ra = 32'h10;
          default: ra = $urandom & 32'hffff_fffc;
        endcase
        rd = ($urandom_range(0, 1) == 0) ? PASS_VAL : $urandom;
        cyc("rnd", rp, rmw, ra, rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
